// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: default widths, opcode map and FSM state encoding.
// The opcode constants are also used by benches as the golden opcode table.
package alu_seq_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned OPRN_WIDTH_DEF = 6;

    // Opcode map, unchanged from the combinational project ALU
    localparam logic [OPRN_WIDTH_DEF-1:0] OP_ADD = 6'h01;
    localparam logic [OPRN_WIDTH_DEF-1:0] OP_SUB = 6'h02;
    localparam logic [OPRN_WIDTH_DEF-1:0] OP_MUL = 6'h03;
    localparam logic [OPRN_WIDTH_DEF-1:0] OP_SHR = 6'h04;
    localparam logic [OPRN_WIDTH_DEF-1:0] OP_SHL = 6'h05;
    localparam logic [OPRN_WIDTH_DEF-1:0] OP_AND = 6'h06;
    localparam logic [OPRN_WIDTH_DEF-1:0] OP_OR  = 6'h07;
    localparam logic [OPRN_WIDTH_DEF-1:0] OP_NOR = 6'h08;
    localparam logic [OPRN_WIDTH_DEF-1:0] OP_SLT = 6'h09;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul_iter.sv
// Iterative radix-2 shift-add multiplier producing the full 2*DATA_WIDTH unsigned product.
// The first partial product is taken on the start edge, so DATA_WIDTH steps finish
// DATA_WIDTH-1 edges after start; done pulses for one cycle with product final.
// Ports:
//   CLK, RST  clock, asynchronous active-high reset
//   start     load operands and take the first step
//   a, b      multiplicand, multiplier (sampled on start)
//   busy      iteration in progress
//   done      one-cycle pulse, product valid
//   product   accumulator, full 2*DATA_WIDTH result
module mul_iter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   product
);

    localparam int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    logic [PROD_WIDTH-1:0] mcand;
    logic [PROD_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] mplier;
    logic [CNT_WIDTH-1:0]  cnt;

    assign product = acc;

    // Shift-add iteration; cnt counts steps already taken
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc    <= b[0] ? PROD_WIDTH'(a) : '0;
                mcand  <= PROD_WIDTH'(a) << 1;
                mplier <= b >> 1;
                cnt    <= CNT_WIDTH'(1);
                busy   <= 1'b1;
            end else if (busy) begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_WIDTH'(1);
                if (cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, one operation in flight.
// Single-cycle ops respond the cycle after accept; mul runs the iterative
// multiplier for DATA_WIDTH cycles first.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   in_valid/in_ready        request handshake (ready only in IDLE)
//   oprn, op1, op2           opcode and operands
//   out_valid/out_ready      response handshake (held in DONE)
//   result, result_hi        result; result_hi is the mul high word, else 0
//   zero, carry, overflow    status flags, meaningful while out_valid
//   err                      unsupported opcode
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned OPRN_WIDTH = OPRN_WIDTH_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPRN_WIDTH-1:0]  oprn,
    input  logic [DATA_WIDTH-1:0]  op1,
    input  logic [DATA_WIDTH-1:0]  op2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  result,
    output logic [DATA_WIDTH-1:0]  result_hi,
    output logic                   zero,
    output logic                   carry,
    output logic                   overflow,
    output logic                   err
);

    localparam int unsigned MSB = DATA_WIDTH - 1;

    state_t state, state_next;

    logic start_c;
    logic load_alu_c;
    logic load_mul_c;

    logic                    mul_busy;
    logic                    mul_done;
    logic [2*DATA_WIDTH-1:0] mul_product;

    logic [DATA_WIDTH:0]     sum_c;
    logic [DATA_WIDTH:0]     diff_c;
    logic                    shift_oob_c;
    logic [DATA_WIDTH-1:0]   alu_result_c;
    logic                    alu_carry_c;
    logic                    alu_ovf_c;
    logic                    alu_err_c;

    mul_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul_iter (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start_c),
        .a       (op1),
        .b       (op2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Extra top bit holds carry-out of add and borrow of sub
    assign sum_c       = {1'b0, op1} + {1'b0, op2};
    assign diff_c      = {1'b0, op1} - {1'b0, op2};
    assign shift_oob_c = (op2 >= DATA_WIDTH'(DATA_WIDTH));

    // Single-cycle datapath, evaluated on the request inputs
    always_comb begin
        alu_result_c = '0;
        alu_carry_c  = 1'b0;
        alu_ovf_c    = 1'b0;
        alu_err_c    = 1'b0;
        case (oprn)
            OPRN_WIDTH'(OP_ADD): begin
                alu_result_c = sum_c[MSB:0];
                alu_carry_c  = sum_c[DATA_WIDTH];
                alu_ovf_c    = (op1[MSB] == op2[MSB]) && (sum_c[MSB] != op1[MSB]);
            end
            OPRN_WIDTH'(OP_SUB): begin
                alu_result_c = diff_c[MSB:0];
                alu_carry_c  = ~diff_c[DATA_WIDTH];
                alu_ovf_c    = (op1[MSB] != op2[MSB]) && (diff_c[MSB] != op1[MSB]);
            end
            OPRN_WIDTH'(OP_MUL): begin
                // produced by mul_iter
            end
            OPRN_WIDTH'(OP_SHR): alu_result_c = shift_oob_c ? '0 : (op1 >> op2);
            OPRN_WIDTH'(OP_SHL): alu_result_c = shift_oob_c ? '0 : (op1 << op2);
            OPRN_WIDTH'(OP_AND): alu_result_c = op1 & op2;
            OPRN_WIDTH'(OP_OR):  alu_result_c = op1 | op2;
            OPRN_WIDTH'(OP_NOR): alu_result_c = ~(op1 | op2);
            OPRN_WIDTH'(OP_SLT): alu_result_c = DATA_WIDTH'(op1 < op2);
            default:             alu_err_c    = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and load strobes
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        load_alu_c = 1'b0;
        load_mul_c = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (oprn == OPRN_WIDTH'(OP_MUL)) begin
                        start_c    = 1'b1;
                        state_next = MUL;
                    end else begin
                        load_alu_c = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            MUL: begin
                if (mul_done && !mul_busy) begin
                    load_mul_c = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output registers; handshake outputs track the next state so they align with it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            if (load_alu_c) begin
                result    <= alu_result_c;
                result_hi <= '0;
                zero      <= (alu_result_c == '0);
                carry     <= alu_carry_c;
                overflow  <= alu_ovf_c;
                err       <= alu_err_c;
            end else if (load_mul_c) begin
                result    <= mul_product[DATA_WIDTH-1:0];
                result_hi <= mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
                zero      <= (mul_product[DATA_WIDTH-1:0] == '0);
                carry     <= 1'b0;
                overflow  <= 1'b0;
                err       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (DATA_WIDTH=32).
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int unsigned W = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [5:0]    oprn = '0;
    logic [W-1:0]  op1 = '0;
    logic [W-1:0]  op2 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          zero;
    logic          carry;
    logic          overflow;
    logic          err;

    int errors = 0;
    int checks = 0;

    alu_seq #(
        .DATA_WIDTH (W),
        .OPRN_WIDTH (6)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .oprn      (oprn),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    // Present a request for one edge; caller guarantees in_ready. Returns #1 after the accept edge.
    task automatic send(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        oprn     = op;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    // Accept the pending response
    task automatic drain();
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++;
        if (result !== '0 || result_hi !== '0) begin
            errors++; $display("FAIL reset_result: got %h_%h want 0", result_hi, result);
        end
        checks++;
        if ({zero, carry, overflow, err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {zero, carry, overflow, err});
        end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_simple_ops();
        logic [5:0]   ops [5];
        logic [W-1:0] va  [5];
        logic [W-1:0] vb  [5];
        logic [W-1:0] exp [5];
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR};
        va  = '{32'd3, 32'd3, 32'd9, 32'd5, 32'd5};
        vb  = '{32'd13, 32'd2, 32'd9, 32'd0, 32'd8};
        exp = '{32'd16, 32'd1, 32'd9, 32'd5, 32'hFFFF_FFF2};
        for (int i = 0; i < 5; i++) begin
            send(ops[i], va[i], vb[i]);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL simple_latency[%0d]: out_valid=%0b want 1", i, out_valid);
            end
            checks++;
            if (result !== exp[i] || result_hi !== '0) begin
                errors++; $display("FAIL simple_result[%0d]: got %h_%h want 0_%h", i, result_hi, result, exp[i]);
            end
            drain();
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] va  [2];
        logic [W-1:0] vb  [2];
        logic [W-1:0] elo [2];
        logic [W-1:0] ehi [2];
        int bad;
        va  = '{32'd7, 32'hFFFF_FFFF};
        vb  = '{32'd7, 32'hFFFF_FFFF};
        elo = '{32'd49, 32'd1};
        ehi = '{32'd0, 32'hFFFF_FFFE};
        for (int i = 0; i < 2; i++) begin
            send(OP_MUL, va[i], vb[i]);
            bad = 0;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
            for (int k = 1; k < W; k++) begin
                @(posedge CLK);
                #1;
                if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL mul_busy[%0d]: %0d cycles with out_valid or in_ready high, want 0", i, bad);
            end
            @(posedge CLK);
            #1;
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL mul_latency[%0d]: out_valid=%0b want 1", i, out_valid);
            end
            checks++;
            if (result !== elo[i] || result_hi !== ehi[i]) begin
                errors++; $display("FAIL mul_result[%0d]: got %h_%h want %h_%h", i, result_hi, result, ehi[i], elo[i]);
            end
            drain();
        end
    endtask

    task automatic test_shift_slt();
        logic [5:0]   ops [6];
        logic [W-1:0] va  [6];
        logic [W-1:0] vb  [6];
        logic [W-1:0] exp [6];
        logic         ez  [6];
        ops = '{OP_SHR, OP_SHL, OP_SHL, OP_SHR, OP_SLT, OP_SLT};
        va  = '{32'd8, 32'd1, 32'd1, 32'h8000_0000, 32'd16, 32'd76};
        vb  = '{32'd1, 32'd2, 32'd32, 32'd31, 32'd76, 32'd16};
        exp = '{32'd4, 32'd4, 32'd0, 32'd1, 32'd1, 32'd0};
        ez  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            send(ops[i], va[i], vb[i]);
            checks++;
            if (out_valid !== 1'b1 || result !== exp[i] || zero !== ez[i]) begin
                errors++;
                $display("FAIL shift_slt[%0d]: valid=%0b result=%h zero=%0b want 1/%h/%0b",
                         i, out_valid, result, zero, exp[i], ez[i]);
            end
            drain();
        end
    endtask

    task automatic test_flags();
        logic [5:0]   ops [7];
        logic [W-1:0] va  [7];
        logic [W-1:0] vb  [7];
        logic [W-1:0] exp [7];
        logic [3:0]   ef  [7];   // {zero, carry, overflow, err}
        ops = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB, 6'h0A, 6'h00};
        va  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd2, 32'h8000_0000, 32'd5, 32'd5};
        vb  = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd1, 32'd6, 32'd6};
        exp = '{32'h8000_0000, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0};
        ef  = '{4'b0001 << 1, 4'b1100, 4'b0100, 4'b0000, 4'b0110, 4'b1001, 4'b1001};
        for (int i = 0; i < 7; i++) begin
            send(ops[i], va[i], vb[i]);
            checks++;
            if (out_valid !== 1'b1 || result !== exp[i] || {zero, carry, overflow, err} !== ef[i]) begin
                errors++;
                $display("FAIL flags[%0d]: valid=%0b result=%h zcve=%b want 1/%h/%b",
                         i, out_valid, result, {zero, carry, overflow, err}, exp[i], ef[i]);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        int bad;
        send(OP_ADD, 32'd45, 32'd15);
        // Second request waits on the bus while the first response is stalled
        @(negedge CLK);
        oprn     = OP_SUB;
        op1      = 32'd50;
        op2      = 32'd8;
        in_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK);
            #1;
            if (out_valid !== 1'b1 || result !== 32'd60 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL backpressure_hold: %0d unstable cycles, result=%0d want 60", bad, result);
        end
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL backpressure_release: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
        end
        @(negedge CLK);
        out_ready = 1'b0;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd42) begin
            errors++; $display("FAIL backpressure_second: out_valid=%0b result=%0d want 1/42", out_valid, result);
        end
        drain();
    endtask

    task automatic test_reset_mid_mul();
        int bad;
        send(OP_MUL, 32'd7, 32'd7);
        repeat (4) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== '0 || result_hi !== '0) begin
            errors++; $display("FAIL reset_mid_mul_clear: out_valid=%0b result=%h_%h want 0/0", out_valid, result_hi, result);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_mul_ready: got %0b want 1", in_ready);
        end
        @(negedge CLK);
        RST       = 1'b0;
        out_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        out_ready = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL reset_mid_mul_abort: %0d cycles with stray response or busy, want 0", bad);
        end
        send(OP_ADD, 32'd1, 32'd1);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd2) begin
            errors++; $display("FAIL reset_recover: out_valid=%0b result=%0d want 1/2", out_valid, result);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_simple_ops();
        test_mul();
        test_shift_slt();
        test_flags();
        test_backpressure();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
